// File: rtl/imm_extend_pipe_pkg.sv
// Shared types for the pipelined immediate extender.
// The mode enum doubles as the set of mode constants used by the datapath.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'd0,
        MODE_ZERO   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } mode_t;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle between an immediate producer and the extender pipe.
// The slave side is the extender; the master side feeds and drains it.
interface imm_extend_pipe_if
    import imm_ext_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int TAG_W   = 5,
    parameter int COUNT_W = 16
) ();

    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    mode_t              in_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic [COUNT_W-1:0] xfer_count;

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, xfer_count
    );

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, xfer_count
    );

endinterface

// File: rtl/imm_extend_pipe_core.sv
// Purely combinational width/mode arithmetic for the immediate extender.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [IN_W-1:0]  data_i,
    input  mode_t            mode_i,
    output logic [OUT_W-1:0] data_o
);

    localparam int PAD = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;

    assign sext = {{PAD{data_i[IN_W-1]}}, data_i};

    // Branch offsets reuse the sign-extended value; bits shifted past OUT_W are dropped.
    always_comb begin
        data_o = sext;
        case (mode_i)
            MODE_SIGN:   data_o = sext;
            MODE_ZERO:   data_o = {{PAD{1'b0}}, data_i};
            MODE_UPPER:  data_o = {data_i, {PAD{1'b0}}};
            MODE_BRANCH: data_o = sext << BR_SHIFT;
            default:     data_o = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a one-entry skid buffer and a transfer counter.
// in_ready depends only on skid occupancy, so no combinational path from out_ready.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    imm_extend_pipe_if.slave    bus
);

    logic [OUT_W-1:0]   extData;

    logic               mainValid_q, mainValid_d;
    logic [OUT_W-1:0]   mainData_q,  mainData_d;
    logic [TAG_W-1:0]   mainTag_q,   mainTag_d;
    logic               skidValid_q, skidValid_d;
    logic [OUT_W-1:0]   skidData_q,  skidData_d;
    logic [TAG_W-1:0]   skidTag_q,   skidTag_d;
    logic [COUNT_W-1:0] count_q,     count_d;

    logic               acc;
    logic               drn;

    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) uCore (
        .data_i (bus.in_data),
        .mode_i (bus.in_mode),
        .data_o (extData)
    );

    assign acc = bus.in_valid & ~skidValid_q;
    assign drn = mainValid_q & bus.out_ready;

    // The skid entry only fills while main is stalled, and always refills main first on drain.
    always_comb begin
        mainValid_d = mainValid_q;
        mainData_d  = mainData_q;
        mainTag_d   = mainTag_q;
        skidValid_d = skidValid_q;
        skidData_d  = skidData_q;
        skidTag_d   = skidTag_q;
        if (!mainValid_q) begin
            if (acc) begin
                mainValid_d = 1'b1;
                mainData_d  = extData;
                mainTag_d   = bus.in_tag;
            end
        end else if (drn) begin
            if (skidValid_q) begin
                mainData_d  = skidData_q;
                mainTag_d   = skidTag_q;
                skidValid_d = 1'b0;
            end else if (acc) begin
                mainData_d  = extData;
                mainTag_d   = bus.in_tag;
            end else begin
                mainValid_d = 1'b0;
            end
        end else if (acc) begin
            skidValid_d = 1'b1;
            skidData_d  = extData;
            skidTag_d   = bus.in_tag;
        end
    end

    assign count_d = drn ? count_q + COUNT_W'(1) : count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mainValid_q <= 1'b0;
            mainData_q  <= '0;
            mainTag_q   <= '0;
            skidValid_q <= 1'b0;
            skidData_q  <= '0;
            skidTag_q   <= '0;
            count_q     <= '0;
        end else begin
            mainValid_q <= mainValid_d;
            mainData_q  <= mainData_d;
            mainTag_q   <= mainTag_d;
            skidValid_q <= skidValid_d;
            skidData_q  <= skidData_d;
            skidTag_q   <= skidTag_d;
            count_q     <= count_d;
        end
    end

    assign bus.in_ready   = ~skidValid_q;
    assign bus.out_valid  = mainValid_q;
    assign bus.out_data   = mainData_q;
    assign bus.out_tag    = mainTag_q;
    assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a two-entry FIFO model scored every cycle plus literal spot checks.
// A second instance with a 4-bit counter shares the stimulus to observe counter wrap.
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    localparam int IN_W     = 16;
    localparam int OUT_W    = 32;
    localparam int BR_SHIFT = 2;
    localparam int TAG_W    = 5;
    localparam int COUNT_W  = 16;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
    } beat_t;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    beat_t       modelQ[$];
    int unsigned modelCount = 0;
    bit          modelLive  = 0;
    bit          accM;
    bit          drnM;

    imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W), .COUNT_W(COUNT_W)) bus ();
    imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W), .COUNT_W(4)) bus4 ();

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_data   = bus.in_data;
    assign bus4.in_mode   = bus.in_mode;
    assign bus4.in_tag    = bus.in_tag;
    assign bus4.out_ready = bus.out_ready;

    imm_extend_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(BR_SHIFT), .TAG_W(TAG_W), .COUNT_W(COUNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    imm_extend_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(BR_SHIFT), .TAG_W(TAG_W), .COUNT_W(4)
    ) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [OUT_W-1:0] expectExt(logic [IN_W-1:0] d, mode_t m);
        longint sv;
        longint r;
        sv = longint'(d);
        if (d[IN_W-1]) sv = sv - (longint'(1) << IN_W);
        case (m)
            MODE_SIGN:   r = sv;
            MODE_ZERO:   r = longint'(d);
            MODE_UPPER:  r = longint'(d) * (longint'(1) << (OUT_W - IN_W));
            default:     r = sv * (longint'(1) << BR_SHIFT);
        endcase
        return r[OUT_W-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the pipe behaves as a two-entry FIFO whose head is shown on out_*.
    always @(posedge clk) begin
        if (reset) begin
            modelQ.delete();
            modelCount = 0;
            modelLive  = 1;
        end else if (modelLive) begin
            accM = bus.in_valid && (modelQ.size() < 2);
            drnM = (modelQ.size() > 0) && bus.out_ready;
            if (drnM) begin
                void'(modelQ.pop_front());
                modelCount++;
            end
            if (accM) modelQ.push_back('{data: expectExt(bus.in_data, bus.in_mode), tag: bus.in_tag});
        end
    end

    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("out_valid", 64'(bus.out_valid), 64'(modelQ.size() > 0));
            checkOutput("in_ready", 64'(bus.in_ready), 64'(modelQ.size() < 2));
            checkOutput("xfer_count", 64'(bus.xfer_count), 64'(modelCount % 65536));
            checkOutput("xfer_count_w4", 64'(bus4.xfer_count), 64'(modelCount % 16));
            if (modelQ.size() > 0) begin
                checkOutput("out_data", 64'(bus.out_data), 64'(modelQ[0].data));
                checkOutput("out_tag", 64'(bus.out_tag), 64'(modelQ[0].tag));
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [IN_W-1:0] d, input mode_t m,
                                 input logic [TAG_W-1:0] t, input logic rdy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.in_tag    = t;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int  accepted;
    int  cycles;
    bit  v;
    bit  hs;

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = MODE_SIGN;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_out_data", 64'(bus.out_data), 64'd0);
        checkOutput("rst_out_tag", 64'(bus.out_tag), 64'd0);
        checkOutput("rst_count", 64'(bus.xfer_count), 64'd0);

        applyStimulus(1'b1, 16'h8001, MODE_SIGN, 5'd3, 1'b1);
        checkOutput("sign_neg", 64'(bus.out_data), 64'hFFFF8001);
        checkOutput("sign_neg_tag", 64'(bus.out_tag), 64'd3);
        applyStimulus(1'b1, 16'h7FFF, MODE_SIGN, 5'd4, 1'b1);
        checkOutput("sign_pos", 64'(bus.out_data), 64'h00007FFF);
        checkOutput("sign_pos_tag", 64'(bus.out_tag), 64'd4);
        applyStimulus(1'b1, 16'h8001, MODE_ZERO, 5'd5, 1'b1);
        checkOutput("zero", 64'(bus.out_data), 64'h00008001);
        applyStimulus(1'b1, 16'h1234, MODE_UPPER, 5'd6, 1'b1);
        checkOutput("upper", 64'(bus.out_data), 64'h12340000);
        applyStimulus(1'b1, 16'hFFFF, MODE_BRANCH, 5'd7, 1'b1);
        checkOutput("branch_neg", 64'(bus.out_data), 64'hFFFFFFFC);
        applyStimulus(1'b1, 16'h0003, MODE_BRANCH, 5'd8, 1'b1);
        checkOutput("branch_pos", 64'(bus.out_data), 64'h0000000C);
        applyStimulus(1'b0, 16'h0000, MODE_SIGN, 5'd0, 1'b1);
        checkOutput("drained", 64'(bus.out_valid), 64'd0);
        checkOutput("directed_count", 64'(bus.xfer_count), 64'd6);

        // Backpressure: A sits in main, B lands in the skid entry.
        doReset();
        applyStimulus(1'b1, 16'h0005, MODE_SIGN, 5'd1, 1'b0);
        checkOutput("bp_a_data", 64'(bus.out_data), 64'h00000005);
        checkOutput("bp_a_ready", 64'(bus.in_ready), 64'd1);
        applyStimulus(1'b1, 16'h8000, MODE_ZERO, 5'd2, 1'b0);
        checkOutput("bp_skid_full", 64'(bus.in_ready), 64'd0);
        checkOutput("bp_a_stable", 64'(bus.out_data), 64'h00000005);
        checkOutput("bp_a_tag", 64'(bus.out_tag), 64'd1);
        applyStimulus(1'b0, 16'h0000, MODE_SIGN, 5'd0, 1'b0);
        checkOutput("bp_hold", 64'(bus.out_data), 64'h00000005);
        checkOutput("bp_hold_count", 64'(bus.xfer_count), 64'd0);
        applyStimulus(1'b0, 16'h0000, MODE_SIGN, 5'd0, 1'b1);
        checkOutput("bp_b_data", 64'(bus.out_data), 64'h00008000);
        checkOutput("bp_b_tag", 64'(bus.out_tag), 64'd2);
        checkOutput("bp_count1", 64'(bus.xfer_count), 64'd1);
        applyStimulus(1'b0, 16'h0000, MODE_SIGN, 5'd0, 1'b1);
        checkOutput("bp_count2", 64'(bus.xfer_count), 64'd2);
        checkOutput("bp_empty", 64'(bus.out_valid), 64'd0);

        // Random streaming of 100 accepted beats under random backpressure.
        doReset();
        accepted = 0;
        cycles   = 0;
        while (accepted < 100 && cycles < 2000) begin
            v  = ($urandom_range(0, 9) < 7);
            hs = v && bus.in_ready;
            applyStimulus(v, IN_W'($urandom), mode_t'($urandom_range(0, 3)),
                          TAG_W'($urandom), 1'($urandom_range(0, 1)));
            if (hs) accepted++;
            cycles++;
        end
        checkOutput("stream_budget", 64'(accepted), 64'd100);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && bus.out_valid; i++) applyStimulus(1'b0, '0, MODE_SIGN, '0, 1'b1);
        checkOutput("stream_count", 64'(bus.xfer_count), 64'd100);
        checkOutput("stream_empty", 64'(bus.out_valid), 64'd0);

        // Counter wrap on the 4-bit instance.
        doReset();
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, IN_W'($urandom), MODE_ZERO, TAG_W'(i), 1'b1);
        applyStimulus(1'b0, '0, MODE_SIGN, '0, 1'b1);
        checkOutput("wrap_w4", 64'(bus4.xfer_count), 64'd1);
        checkOutput("wrap_w16", 64'(bus.xfer_count), 64'd17);

        // Reset with main and skid both holding beats, while input is offered.
        doReset();
        applyStimulus(1'b1, 16'h0011, MODE_SIGN, 5'd9, 1'b0);
        applyStimulus(1'b1, 16'h0022, MODE_SIGN, 5'd10, 1'b0);
        checkOutput("mid_full", 64'(bus.in_ready), 64'd0);
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h00AA;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("mid_rst_count", 64'(bus.xfer_count), 64'd0);
        checkOutput("mid_rst_data", 64'(bus.out_data), 64'd0);
        applyStimulus(1'b1, 16'h1234, MODE_UPPER, 5'd7, 1'b1);
        checkOutput("post_rst_data", 64'(bus.out_data), 64'h12340000);
        checkOutput("post_rst_tag", 64'(bus.out_tag), 64'd7);
        applyStimulus(1'b0, '0, MODE_SIGN, '0, 1'b1);
        checkOutput("post_rst_count", 64'(bus.xfer_count), 64'd1);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate extender for the datapath. Successor to the fixed 16->32 combinational sign extender.
- Takes an IN_W-bit immediate plus a mode: sign-extend, zero-extend, upper-place (lui-style) or sign-extend-and-shift (branch offset).
- Produces an OUT_W-bit result through a registered output stage with valid/ready handshake and a one-entry skid buffer, so it can sit between pipeline stages under backpressure.
- Keeps a wrap-around count of completed output transfers.

Parameters:
IN_W, 16, immediate input width; legal range 1..OUT_W-1
OUT_W, 32, extended output width; must satisfy OUT_W > IN_W
BR_SHIFT, 2, left shift applied in MODE_BRANCH; legal range 0..OUT_W-1
TAG_W, 5, width of sideband tag carried alongside the data (e.g. destination register)
COUNT_W, 16, width of the transfer counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept an input beat this cycle
in_data  input  IN_W  raw immediate
in_mode  input  2  extension mode (package constants)
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  out_data/out_tag valid
out_ready  input  1  downstream accepts this cycle
out_data  output  OUT_W  extended result
out_tag  output  TAG_W  tag belonging to out_data
xfer_count  output  COUNT_W  number of completed output handshakes, modulo 2^COUNT_W

Behaviour:
- Handshakes:
  - Input handshake = in_valid & in_ready.
  - Output handshake = out_valid & out_ready.
  - out_data and out_tag stay stable while out_valid=1 and out_ready=0.
- Mode arithmetic (combinational, before the register), d = in_data:
  - MODE_SIGN (0): {(OUT_W-IN_W) copies of d[IN_W-1], d}.
  - MODE_ZERO (1): {(OUT_W-IN_W) zeros, d}.
  - MODE_UPPER (2): d placed in out[OUT_W-1 -: IN_W]; low OUT_W-IN_W bits are zero.
  - MODE_BRANCH (3): sign-extended value shifted left BR_SHIFT; result truncated to OUT_W; vacated low bits are zero.
- Storage: output register (main) and skid register (skid), each holding {data, tag, valid}.
- in_ready = ~skid.valid. It is registered state, with no combinational path from out_ready.
- Latency: an accepted beat appears on out_* the next cycle when main is empty or being drained. Throughput is one beat per cycle under continuous out_ready=1.
- Per-cycle update, with acc = input handshake and drn = output handshake:
  - main empty: acc loads main.
  - main full, drn, skid empty: acc loads main, otherwise main is cleared.
  - main full, drn, skid full: skid moves into main and skid is cleared (acc is impossible because in_ready=0).
  - main full, no drn, acc: beat goes into skid, so in_ready=0 next cycle.
  - main full, no drn, no acc: hold.
- Ordering is strictly FIFO; no beat is lost or duplicated.
- xfer_count increments by 1 on each output handshake. It wraps from all-ones to 0.
- Reset, while reset=1 at a clock edge:
  - main.valid and skid.valid go to 0; out_valid=0.
  - out_data=0, out_tag=0, xfer_count=0.
  - in_ready=1 from the cycle after reset.
  - Input presented in a cycle where reset=1 is discarded.
  - Reset mid-transfer drops any held beats and the counter does not increment for them.
- No X propagation: data registers load only on their valid conditions. Mode decoding is total (all four codes defined).

Decomposition:
- Package imm_ext_pkg:
  - mode constants MODE_SIGN=2'd0, MODE_ZERO=2'd1, MODE_UPPER=2'd2, MODE_BRANCH=2'd3;
  - mode typedef (2-bit).
- Sub-module imm_ext_core: purely combinational mode/width arithmetic, parameterised by IN_W, OUT_W, BR_SHIFT.
- imm_extend_pipe instantiates imm_ext_core and adds the skid/handshake/counter logic.

Test Plan:
- IN_W=16, OUT_W=32, out_ready=1, MODE_SIGN with 0x8001 then 0x7FFF -> next-cycle out_data 0xFFFF8001 then 0x00007FFF, with matching tags.
- MODE_ZERO with 0x8001 -> 0x00008001. MODE_UPPER with 0x1234 -> 0x12340000.
- MODE_BRANCH, BR_SHIFT=2: 0xFFFF -> 0xFFFFFFFC; 0x0003 -> 0x0000000C.
- Backpressure:
  - out_ready=0, send A (tag 1) then B (tag 2) -> A held stable on out_*, in_ready=0 the cycle after B is accepted.
  - Raise out_ready -> A then B in consecutive cycles, xfer_count 0->1->2.
- Continuous streaming of 100 random beats with random out_ready -> scoreboard order and values match, xfer_count=100.
- Reset mid-operation with main and skid both full -> next cycle out_valid=0, in_ready=1, xfer_count=0. Then a new beat passes normally.
- COUNT_W=4 with 17 transfers -> xfer_count reads 1 (wrap verified).
